fifo_write: RTL and testbench



---
 rtl/fifo_write_pkg.sv | 16 +
 rtl/fifo_write.sv | 113 +++++++++++
 tb/tb_fifo_write.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_write_pkg.sv
// Shared TX framing definitions: state codes, header bytes, frame overhead.
// Also used by the FIFO-to-MAC TX block and the PC-side decoder.
package fifo_write_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LATCH = 3'd1,
        S_WRITE = 3'd2,
        S_DONE  = 3'd3
    } state_t;

    localparam logic [7:0] HEAD0_DEF = 8'h55;
    localparam logic [7:0] HEAD1_DEF = 8'hAA;
    localparam int         FRAME_OVH = 4;

endpackage

// File: rtl/fifo_write.sv
// Transmit-side framer: snapshots a result word and writes
// header, length, payload and XOR checksum into the TX FIFO.
module fifo_write
    import fifo_write_pkg::*;
#(
    parameter int          DATA_BYTES = 12,
    parameter logic [7:0]  HEAD0      = HEAD0_DEF,
    parameter logic [7:0]  HEAD1      = HEAD1_DEF,
    parameter logic [15:0] TIMEOUT    = 16'd1000
) (
    input  logic                    sys_clk,
    input  logic                    rst,
    input  logic                    fs,
    output logic                    fd,
    input  logic [8*DATA_BYTES-1:0] dat,
    output logic [7:0]              fifo_txd,
    output logic                    fifo_txen,
    input  logic                    fifo_full,
    output logic [11:0]             eth_tx_len,
    output logic                    err,
    output logic [2:0]              so
);

    localparam logic [7:0]  LEN_B = 8'(DATA_BYTES);
    localparam logic [7:0]  LAST  = 8'(DATA_BYTES + 3);
    localparam logic [11:0] FLEN  = 12'(DATA_BYTES + FRAME_OVH);

    state_t state, next;

    logic [8*DATA_BYTES-1:0] snap;
    logic [7:0]  idx;
    logic [7:0]  chk;
    logic [15:0] stall;
    logic [7:0]  cur;
    logic [7:0]  pay;
    logic        in_write;
    logic        wr;
    logic        tmo;

    assign in_write  = (state == S_WRITE);
    assign wr        = in_write & ~fifo_full;
    assign tmo       = in_write & fifo_full & (stall == TIMEOUT - 16'd1);
    assign fifo_txen = wr;
    assign fifo_txd  = in_write ? cur : 8'h00;
    assign so        = state;

    // payload byte k sits at idx k+3, MSB byte of the snapshot first
    always_comb begin
        pay = 8'h00;
        for (int i = 0; i < DATA_BYTES; i++) begin
            if (idx == 8'(i + 3))
                pay = snap[8*(DATA_BYTES-1-i) +: 8];
        end
    end

    always_comb begin
        cur = pay;
        if (idx == 8'd0)
            cur = HEAD0;
        else if (idx == 8'd1)
            cur = HEAD1;
        else if (idx == 8'd2)
            cur = LEN_B;
        else if (idx == LAST)
            cur = chk;
    end

    always_comb begin
        next = state;
        unique case (state)
            S_IDLE:  if (fs) next = S_LATCH;
            S_LATCH: next = S_WRITE;
            S_WRITE: if ((wr && idx == LAST) || tmo) next = S_DONE;
            S_DONE:  if (!fs) next = S_IDLE;
            default: next = S_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            fd         <= 1'b0;
            eth_tx_len <= 12'd0;
            err        <= 1'b0;
            idx        <= 8'd0;
            chk        <= 8'd0;
            stall      <= 16'd0;
            snap       <= '0;
        end else begin
            state <= next;
            fd    <= (next == S_DONE);
            if (state == S_LATCH) begin
                snap       <= dat;
                idx        <= 8'd0;
                chk        <= 8'd0;
                stall      <= 16'd0;
                err        <= 1'b0;
                eth_tx_len <= FLEN;
            end else if (wr) begin
                idx   <= idx + 8'd1;
                stall <= 16'd0;
                if (idx >= 8'd2 && idx < LAST)
                    chk <= chk ^ cur;
            end else if (in_write) begin
                if (tmo)
                    err <= 1'b1;
                else
                    stall <= stall + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_fifo_write.sv
// Scoreboard bench for fifo_write: default instance plus a
// short-timeout instance for the abort path.
module tb_fifo_write;

    logic        sys_clk = 1'b0;
    logic        rst = 1'b1;

    logic        fs = 1'b0, fd;
    logic [95:0] dat = '0;
    logic [7:0]  txd;
    logic        txen, full = 1'b0;
    logic [11:0] len;
    logic        err;
    logic [2:0]  so;

    logic        fs2 = 1'b0, fd2;
    logic [95:0] dat2 = '0;
    logic [7:0]  txd2;
    logic        txen2, full2 = 1'b0;
    logic [11:0] len2;
    logic        err2;
    logic [2:0]  so2;

    int compared = 0;
    int mismatched = 0;
    int wr1 = 0;
    int wr2 = 0;
    logic [7:0] q1[$];
    logic [7:0] q2[$];

    always #5 sys_clk = ~sys_clk;

    fifo_write dut (
        .sys_clk(sys_clk), .rst(rst), .fs(fs), .fd(fd), .dat(dat),
        .fifo_txd(txd), .fifo_txen(txen), .fifo_full(full),
        .eth_tx_len(len), .err(err), .so(so)
    );

    fifo_write #(.TIMEOUT(16'd8)) dut2 (
        .sys_clk(sys_clk), .rst(rst), .fs(fs2), .fd(fd2), .dat(dat2),
        .fifo_txd(txd2), .fifo_txen(txen2), .fifo_full(full2),
        .eth_tx_len(len2), .err(err2), .so(so2)
    );

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic fail_now(input string name);
        compared++;
        mismatched++;
        $display("FAIL %s: bound expired or unexpected event", name);
    endtask

    // monitors: every write must match the next expected byte
    always @(negedge sys_clk) begin
        if (txen === 1'b1) begin
            if (q1.size() == 0) fail_now("dut write with empty scoreboard");
            else check("dut byte", {24'd0, txd}, {24'd0, q1.pop_front()});
            wr1++;
        end
    end

    always @(negedge sys_clk) begin
        if (txen2 === 1'b1) begin
            if (q2.size() == 0) fail_now("dut2 write with empty scoreboard");
            else check("dut2 byte", {24'd0, txd2}, {24'd0, q2.pop_front()});
            wr2++;
        end
    end

    task automatic push(input int which, input logic [95:0] d,
                        input logic [7:0] c, input int nbytes);
        logic [7:0] f[16];
        f[0] = 8'h55;
        f[1] = 8'hAA;
        f[2] = 8'h0C;
        for (int i = 0; i < 12; i++) f[3+i] = d[95-8*i -: 8];
        f[15] = c;
        for (int i = 0; i < nbytes; i++) begin
            if (which == 1) q1.push_back(f[i]);
            else q2.push_back(f[i]);
        end
    endtask

    task automatic wait_wr(input int which, input int n, input string name);
        int k = 0;
        while (((which == 1) ? wr1 : wr2) < n && k < 300) begin
            @(posedge sys_clk); #1;
            k++;
        end
        if (((which == 1) ? wr1 : wr2) < n) fail_now(name);
    endtask

    task automatic wait_fd(input int which, input string name);
        int k = 0;
        while (((which == 1) ? fd : fd2) !== 1'b1 && k < 300) begin
            @(posedge sys_clk); #1;
            k++;
        end
        if (((which == 1) ? fd : fd2) !== 1'b1) fail_now(name);
    endtask

    task automatic end_frame();
        @(posedge sys_clk); #1;
        fs = 1'b0;
        repeat (2) @(posedge sys_clk);
        #1;
    endtask

    initial begin
        logic [18:0] pat;
        int base, hits, n;

        #12;
        check("reset txen", {31'd0, txen}, 0);
        check("reset txd", {24'd0, txd}, 0);
        check("reset fd", {31'd0, fd}, 0);
        check("reset err", {31'd0, err}, 0);
        check("reset so", {29'd0, so}, 0);
        check("reset len", {20'd0, len}, 0);
        @(negedge sys_clk);
        rst = 1'b0;

        // basic frame, cycle-accurate write window
        base = wr1;
        dat = 96'h0102030405060708090A0B0C;
        push(1, dat, 8'h00, 16);
        @(posedge sys_clk); #1;
        fs = 1'b1;
        @(posedge sys_clk);
        pat = '0;
        for (int c = 1; c <= 18; c++) begin
            @(negedge sys_clk);
            pat[c] = txen;
        end
        check("t1 txen cycles 2..17", {13'd0, pat}, 32'h3FFFC);
        check("t1 fd at cycle 18", {31'd0, fd}, 1);
        check("t1 so done", {29'd0, so}, 3);
        check("t1 len", {20'd0, len}, 16);
        check("t1 err", {31'd0, err}, 0);
        check("t1 count", wr1 - base, 16);
        end_frame();

        // all-FF payload, fd holds while fs is high
        base = wr1;
        dat = {12{8'hFF}};
        push(1, dat, 8'h0C, 16);
        fs = 1'b1;
        wait_fd(1, "t2 fd");
        hits = 0;
        repeat (4) begin
            @(negedge sys_clk);
            if (fd !== 1'b1) hits++;
        end
        check("t2 fd held", hits, 0);
        @(posedge sys_clk); #1;
        fs = 1'b0;
        @(posedge sys_clk);
        @(negedge sys_clk);
        check("t2 fd low after fs drop", {31'd0, fd}, 0);
        check("t2 so idle", {29'd0, so}, 0);
        check("t2 count", wr1 - base, 16);
        @(posedge sys_clk); #1;

        // five full cycles after the third byte
        base = wr1;
        dat = 96'h0102030405060708090A0B0C;
        push(1, dat, 8'h00, 16);
        fs = 1'b1;
        wait_wr(1, base + 3, "t3 third byte");
        full = 1'b1;
        hits = 0;
        repeat (5) begin
            @(negedge sys_clk);
            if (txen !== 1'b0) hits++;
        end
        @(posedge sys_clk); #1;
        full = 1'b0;
        @(negedge sys_clk);
        check("t3 txen during stall", hits, 0);
        check("t3 resume txen", {31'd0, txen}, 1);
        check("t3 resume byte", {24'd0, txd}, 32'h01);
        wait_fd(1, "t3 fd");
        check("t3 count", wr1 - base, 16);
        check("t3 err", {31'd0, err}, 0);
        end_frame();

        // reset mid-frame at idx 7
        base = wr1;
        push(1, dat, 8'h00, 16);
        fs = 1'b1;
        wait_wr(1, base + 7, "t4 seventh byte");
        rst = 1'b1;
        #1;
        check("t4 rst txen", {31'd0, txen}, 0);
        check("t4 rst txd", {24'd0, txd}, 0);
        check("t4 rst fd", {31'd0, fd}, 0);
        check("t4 rst so", {29'd0, so}, 0);
        check("t4 rst len", {20'd0, len}, 0);
        check("t4 written before rst", wr1 - base, 7);
        q1.delete();
        fs = 1'b0;
        @(negedge sys_clk);
        rst = 1'b0;
        @(posedge sys_clk); #1;
        base = wr1;
        dat = 96'h800000000000000000000001;
        push(1, dat, 8'h8D, 16);
        fs = 1'b1;
        wait_fd(1, "t4 fd");
        check("t4 new frame count", wr1 - base, 16);
        end_frame();

        // fs dropped mid-frame
        base = wr1;
        dat = 96'h102030405060708090A0B0C0;
        push(1, dat, 8'hCC, 16);
        fs = 1'b1;
        repeat (4) @(posedge sys_clk);
        #1;
        fs = 1'b0;
        hits = 0;
        repeat (25) begin
            @(negedge sys_clk);
            if (fd === 1'b1) hits++;
        end
        check("t5 fd one cycle", hits, 1);
        check("t5 count", wr1 - base, 16);
        check("t5 so idle", {29'd0, so}, 0);

        // timeout abort on the TIMEOUT=8 instance
        base = wr2;
        dat2 = 96'h0102030405060708090A0B0C;
        push(2, dat2, 8'h00, 2);
        fs2 = 1'b1;
        wait_wr(2, base + 2, "t6 second byte");
        full2 = 1'b1;
        n = 0;
        while (fd2 !== 1'b1 && n < 50) begin
            @(negedge sys_clk);
            n++;
        end
        check("t6 cycles to fd", n, 9);
        check("t6 err", {31'd0, err2}, 1);
        repeat (3) @(negedge sys_clk);
        check("t6 count", wr2 - base, 2);
        @(posedge sys_clk); #1;
        fs2 = 1'b0;
        full2 = 1'b0;
        repeat (2) @(posedge sys_clk);
        #1;
        base = wr2;
        push(2, dat2, 8'h00, 16);
        fs2 = 1'b1;
        @(posedge sys_clk);
        @(negedge sys_clk);
        check("t6 err before latch", {31'd0, err2}, 1);
        @(negedge sys_clk);
        check("t6 err cleared", {31'd0, err2}, 0);
        wait_fd(2, "t6 fd2");
        check("t6 next count", wr2 - base, 16);
        @(posedge sys_clk); #1;
        fs2 = 1'b0;
        repeat (3) @(posedge sys_clk);

        check("q1 drained", q1.size(), 0);
        check("q2 drained", q2.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
